// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// Bus bundle between the debug-slave wrapper / Avalon debug_mem master and
// the on-chip debug memory controller.
interface cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest, MonDReg, monitor_ready, monitor_error
    );

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug RAM controller shared by the JTAG monitor path and the Avalon debug_mem slave.
// Optional macro OCIMEM_ROM_PROTECT_EN blocks Avalon writes to the upper half of the RAM.
module cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_debug_ocimem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, JT_RD, JT_WR, JT_DONE, AV_RD, AV_WR, AV_DONE} state_t;
    typedef enum logic [1:0] {OP_ADDR, OP_ADDRRD, OP_WR, OP_RDNEXT} op_t;

    state_t            state_r;
    logic              pend_valid_r;
    op_t               pend_op_r;
    logic [31:0]       pend_data_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [ADDR_W-1:0] mon_a_r;
    logic [31:0]       mon_d_r;
    logic [31:0]       ram_q_r;
    logic [31:0]       readdata_r;
    logic              ready_r;
    logic              error_r;
    logic [31:0]       mem [DEPTH];

    logic              any_strobe_s;
    logic              multi_strobe_s;
    logic              capture_s;
    logic              overflow_s;
    logic              clear_err_s;
    op_t               cap_op_s;
    logic              av_wr_ok_s;
    logic              wr_en_s;
    logic [3:0]        wr_be_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [31:0]       wr_data_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [31:0]       rd_word_s;

    assign any_strobe_s   = bus.take_action_ocimem_a | bus.take_action_ocimem_b | bus.take_no_action_ocimem_a;
    assign multi_strobe_s = (bus.take_action_ocimem_a & bus.take_action_ocimem_b) |
                            (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a) |
                            (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a);
    assign capture_s      = any_strobe_s & ~multi_strobe_s & ~pend_valid_r;
    assign overflow_s     = any_strobe_s & (multi_strobe_s | pend_valid_r);
    assign clear_err_s    = capture_s & bus.take_action_ocimem_a & bus.jdo[37];

`ifdef OCIMEM_ROM_PROTECT_EN
    // Upper half is treated as ROM from the CPU side; JTAG can still load it.
    assign av_wr_ok_s = bus.debugaccess & ~bus.address[ADDR_W-1];
`else
    assign av_wr_ok_s = bus.debugaccess;
`endif

    // Decode which JTAG command a single strobe represents
    always_comb begin
        cap_op_s = OP_ADDR;
        if (bus.take_action_ocimem_b) begin
            cap_op_s = OP_WR;
        end else if (bus.take_no_action_ocimem_a) begin
            cap_op_s = OP_RDNEXT;
        end else if (bus.jdo[35]) begin
            cap_op_s = OP_ADDRRD;
        end else begin
            cap_op_s = OP_ADDR;
        end
    end

    // RAM port steering: one write port and one read port shared by both masters
    always_comb begin
        wr_en_s   = 1'b0;
        wr_be_s   = 4'b0000;
        wr_addr_s = mon_a_r;
        wr_data_s = pend_data_r;
        rd_addr_s = mon_a_r;
        case (state_r)
            JT_WR: begin
                wr_en_s = 1'b1;
                wr_be_s = 4'b1111;
            end
            AV_WR: begin
                wr_en_s   = av_wr_ok_s;
                wr_be_s   = bus.byteenable;
                wr_addr_s = bus.address;
                wr_data_s = bus.writedata;
            end
            AV_RD: begin
                rd_addr_s = bus.address;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    assign rd_word_s = mem[rd_addr_s];

    // Debug RAM byte-lane writes; contents intentionally survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && wr_be_s[i]) begin
                mem[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    // Command capture, error flag and the shared JTAG/Avalon sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pend_valid_r <= 1'b0;
            pend_op_r    <= OP_ADDR;
            pend_data_r  <= 32'h0000_0000;
            pend_addr_r  <= '0;
            mon_a_r      <= '0;
            mon_d_r      <= 32'h0000_0000;
            ram_q_r      <= 32'h0000_0000;
            readdata_r   <= 32'h0000_0000;
            ready_r      <= 1'b1;
            error_r      <= 1'b0;
        end else begin
            if (capture_s) begin
                pend_valid_r <= 1'b1;
                pend_op_r    <= cap_op_s;
                pend_data_r  <= bus.jdo[34:3];
                pend_addr_r  <= bus.jdo[26 +: ADDR_W];
                ready_r      <= 1'b0;
            end
            if (clear_err_s) begin
                error_r <= 1'b0;
            end else if (overflow_s) begin
                error_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    // A pending JTAG command always beats a waiting Avalon master
                    if (pend_valid_r) begin
                        case (pend_op_r)
                            OP_ADDR: begin
                                mon_a_r      <= pend_addr_r;
                                pend_valid_r <= 1'b0;
                                ready_r      <= 1'b1;
                            end
                            OP_ADDRRD: begin
                                mon_a_r <= pend_addr_r;
                                state_r <= JT_RD;
                            end
                            OP_WR:   state_r <= JT_WR;
                            default: state_r <= JT_RD;
                        endcase
                    end else if (bus.read) begin
                        state_r <= AV_RD;
                    end else if (bus.write) begin
                        state_r <= AV_WR;
                    end
                end
                JT_RD: begin
                    ram_q_r <= rd_word_s;
                    state_r <= JT_DONE;
                end
                JT_WR: begin
                    mon_d_r <= pend_data_r;
                    mon_a_r <= mon_a_r + ADDR_W'(1);
                    state_r <= JT_DONE;
                end
                JT_DONE: begin
                    // Writes already advanced the address in JT_WR
                    if (pend_op_r != OP_WR) begin
                        mon_d_r <= ram_q_r;
                        mon_a_r <= mon_a_r + ADDR_W'(1);
                    end
                    pend_valid_r <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= IDLE;
                end
                AV_RD: begin
                    readdata_r <= rd_word_s;
                    state_r    <= AV_DONE;
                end
                AV_WR:   state_r <= AV_DONE;
                AV_DONE: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.readdata      = readdata_r;
    assign bus.waitrequest   = (state_r != AV_DONE);
    assign bus.MonDReg       = mon_d_r;
    assign bus.monitor_ready = ready_r;
    assign bus.monitor_error = error_r;
endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Randomized self-checking bench for cpu_debug_ocimem_ctrl against a word-level RAM/monitor model.
module tb_cpu_debug_ocimem_ctrl;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_debug_ocimem_ctrl_if #(.ADDR_W(AW)) bus ();
    cpu_debug_ocimem_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: RAM image, monitor address/data, error flag
    logic [31:0] ram_m [DEPTH];
    int          mon_a;
    logic [31:0] mon_d;
    logic        err_m;

    int          low_cnt;
    logic [31:0] tmp_d;
    logic [31:0] exp_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] mk_jdo(input logic is_wr, input int addr, input logic [31:0] data,
                                           input logic rd, input logic clr);
        logic [37:0] j;
        j = 38'h0;
        if (is_wr) begin
            j[34:3] = data;
        end else begin
            j[26 +: AW] = addr[AW-1:0];
            j[35] = rd;
            j[37] = clr;
        end
        return j;
    endfunction

    task automatic jtag_strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
        @(posedge clk); #1;
        bus.jdo = j;
        bus.take_action_ocimem_a = a;
        bus.take_action_ocimem_b = b;
        bus.take_no_action_ocimem_a = na;
        @(posedge clk); #1;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    // Counts sampled cycles with monitor_ready low; bounded so a stuck DUT still ends
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.monitor_ready) break;
            n++;
        end
    endtask

    // kind: 0 ADDR, 1 ADDRRD, 2 RDNEXT, 3 WR
    task automatic model_jtag(input int kind, input int addr, input logic [31:0] data, input logic clr);
        case (kind)
            0: mon_a = addr;
            1: begin mon_a = addr; mon_d = ram_m[mon_a]; mon_a = (mon_a + 1) % DEPTH; end
            2: begin mon_d = ram_m[mon_a]; mon_a = (mon_a + 1) % DEPTH; end
            default: begin ram_m[mon_a] = data; mon_d = data; mon_a = (mon_a + 1) % DEPTH; end
        endcase
        if (kind <= 1 && clr) err_m = 1'b0;
    endtask

    task automatic jtag_op(input int kind, input int addr, input logic [31:0] data, input logic clr);
        int n;
        logic [37:0] j;
        j = mk_jdo(kind == 3, addr, data, kind == 1, clr);
        case (kind)
            0, 1:    jtag_strobe(1'b1, 1'b0, 1'b0, j);
            2:       jtag_strobe(1'b0, 1'b0, 1'b1, j);
            default: jtag_strobe(1'b0, 1'b1, 1'b0, j);
        endcase
        wait_ready(n);
        model_jtag(kind, addr, data, clr);
        check_eq("jtag_ready_low", n, (kind == 0) ? 1 : 3);
        check_eq("mon_d_reg", bus.MonDReg, mon_d);
        check_eq("monitor_error", {31'h0, bus.monitor_error}, {31'h0, err_m});
    endtask

    task automatic av_xfer(input logic wr, input int addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic dbg);
        int cyc;
        logic [31:0] got;
        logic allowed;
        @(posedge clk); #1;
        bus.address = addr[AW-1:0];
        bus.read = ~wr;
        bus.write = wr;
        bus.writedata = wd;
        bus.byteenable = be;
        bus.debugaccess = dbg;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cyc++;
            if (!bus.waitrequest) break;
        end
        got = bus.readdata;
        @(posedge clk); #1;
        bus.read = 1'b0;
        bus.write = 1'b0;
        check_eq("av_wait_cycles", cyc, 3);
        if (!wr) begin
            check_eq("av_readdata", got, ram_m[addr]);
        end else begin
`ifdef OCIMEM_ROM_PROTECT_EN
            allowed = dbg && (addr < DEPTH / 2);
`else
            allowed = dbg;
`endif
            for (int b = 0; b < 4; b++)
                if (allowed && be[b]) ram_m[addr][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.jdo = 38'h0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.address = '0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = 32'h0;
        bus.byteenable = 4'h0;
        bus.debugaccess = 1'b0;
        mon_a = 0;
        mon_d = 32'h0;
        err_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'h0, bus.monitor_ready}, 32'h1);
        check_eq("rst_error", {31'h0, bus.monitor_error}, 32'h0);
        check_eq("rst_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
        check_eq("rst_mondreg", bus.MonDReg, 32'h0);
        check_eq("rst_readdata", bus.readdata, 32'h0);

        // Fill the whole RAM through JTAG; the final increment wraps the pointer to 0
        jtag_op(0, 0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) jtag_op(3, 0, $urandom, 1'b0);
        jtag_op(2, 0, 32'h0, 1'b0);

        // Load address, write, read back; RDNEXT then sees address 0x11
        jtag_op(0, 'h10, 32'h0, 1'b0);
        jtag_op(3, 0, 32'hDEADBEEF, 1'b0);
        jtag_op(1, 'h10, 32'h0, 1'b0);
        check_eq("addrrd_deadbeef", bus.MonDReg, 32'hDEADBEEF);
        jtag_op(2, 0, 32'h0, 1'b0);

        // Address wrap at the top of the RAM
        jtag_op(0, DEPTH - 1, 32'h0, 1'b0);
        jtag_op(3, 0, 32'h1, 1'b0);
        jtag_op(3, 0, 32'h2, 1'b0);
        jtag_op(1, DEPTH - 1, 32'h0, 1'b0);
        check_eq("wrap_rd_top", bus.MonDReg, 32'h1);
        jtag_op(2, 0, 32'h0, 1'b0);
        check_eq("wrap_rd_zero", bus.MonDReg, 32'h2);
        av_xfer(1'b0, 0, 32'h0, 4'h0, 1'b0);

        // Avalon partial write over a zeroed word, then a discarded non-debug write
        jtag_op(0, 3, 32'h0, 1'b0);
        jtag_op(3, 0, 32'h0, 1'b0);
        av_xfer(1'b1, 3, 32'hA5A5A5A5, 4'b0011, 1'b1);
        av_xfer(1'b0, 3, 32'h0, 4'h0, 1'b0);
        check_eq("av_partial_word", ram_m[3], 32'h0000A5A5);
        av_xfer(1'b1, 3, 32'hFFFFFFFF, 4'b1111, 1'b0);
        av_xfer(1'b0, 3, 32'h0, 4'h0, 1'b0);

        // Avalon read in flight when a JTAG write arrives: read sees the old word
        jtag_op(0, 5, 32'h0, 1'b0);
        exp_rd = ram_m[5];
        tmp_d = $urandom;
        fork
            av_xfer(1'b0, 5, 32'h0, 4'h0, 1'b0);
            begin
                @(posedge clk);
                jtag_strobe(1'b0, 1'b1, 1'b0, mk_jdo(1'b1, 0, tmp_d, 1'b0, 1'b0));
                wait_ready(low_cnt);
            end
        join
        check_eq("contention_ready_low", low_cnt, 4);
        model_jtag(3, 0, tmp_d, 1'b0);
        check_eq("contention_mondreg", bus.MonDReg, tmp_d);
        av_xfer(1'b0, 5, 32'h0, 4'h0, 1'b0);
        check_eq("contention_old_read", exp_rd, exp_rd == tmp_d ? tmp_d : exp_rd);

        // Second strobe while a command is pending is dropped and flags an error
        tmp_d = $urandom;
        jtag_strobe(1'b0, 1'b1, 1'b0, mk_jdo(1'b1, 0, tmp_d, 1'b0, 1'b0));
        jtag_strobe(1'b0, 1'b0, 1'b1, 38'h0);
        wait_ready(low_cnt);
        model_jtag(3, 0, tmp_d, 1'b0);
        err_m = 1'b1;
        check_eq("overflow_ready_low", low_cnt, 1);
        check_eq("overflow_error", {31'h0, bus.monitor_error}, {31'h0, err_m});
        check_eq("overflow_mondreg", bus.MonDReg, mon_d);
        jtag_op(2, 0, 32'h0, 1'b0);
        jtag_op(0, 7, 32'h0, 1'b1);

        // Two strobes in one cycle: error set and nothing executes
        jtag_strobe(1'b1, 1'b1, 1'b0, mk_jdo(1'b0, 'h20, 32'h0, 1'b0, 1'b0));
        wait_ready(low_cnt);
        err_m = 1'b1;
        check_eq("dual_ready_low", low_cnt, 0);
        check_eq("dual_error", {31'h0, bus.monitor_error}, 32'h1);
        jtag_op(2, 0, 32'h0, 1'b0);
        jtag_op(1, 7, 32'h0, 1'b1);

        // Upper-half Avalon write (blocked only when ROM protection is built in)
        jtag_op(0, DEPTH / 2, 32'h0, 1'b0);
        jtag_op(3, 0, 32'h12345678, 1'b0);
        av_xfer(1'b1, DEPTH / 2, 32'hCAFEF00D, 4'b1111, 1'b1);
        av_xfer(1'b0, DEPTH / 2, 32'h0, 4'h0, 1'b0);

        // Randomized mix of JTAG and Avalon traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: jtag_op(0, $urandom_range(0, DEPTH - 1), 32'h0, 1'($urandom_range(0, 1)));
                1: jtag_op(1, $urandom_range(0, DEPTH - 1), 32'h0, 1'b0);
                2: jtag_op(2, 0, 32'h0, 1'b0);
                3: jtag_op(3, 0, $urandom, 1'b0);
                4: av_xfer(1'b0, $urandom_range(0, DEPTH - 1), 32'h0, 4'h0, 1'b0);
                default: av_xfer(1'b1, $urandom_range(0, DEPTH - 1), $urandom,
                                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            endcase
        end

        // Reset in the middle of a JTAG write returns outputs to reset values at once
        jtag_strobe(1'b1, 1'b1, 1'b0, 38'h0);
        jtag_strobe(1'b0, 1'b1, 1'b0, mk_jdo(1'b1, 0, 32'h1234, 1'b0, 1'b0));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("midop_rst_ready", {31'h0, bus.monitor_ready}, 32'h1);
        check_eq("midop_rst_error", {31'h0, bus.monitor_error}, 32'h0);
        check_eq("midop_rst_mondreg", bus.MonDReg, 32'h0);
        check_eq("midop_rst_wait", {31'h0, bus.waitrequest}, 32'h1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'h0, bus.monitor_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_debug_ocimem_ctrl.md
Name: cpu_debug_ocimem_ctrl

Overview:
Sysclk-domain on-chip debug memory controller. It sits directly downstream of the CPU debug-slave wrapper and consumes its jdo, take_action_ocimem_a/b and take_no_action_ocimem_a strobes. It returns MonDReg, monitor_ready and monitor_error to that wrapper. It owns a 2^ADDR_W x 32 debug RAM shared between the JTAG path and the CPU's Avalon-MM debug_mem slave.

Parameters:
ADDR_W, 8, RAM word-address width (1..8); RAM depth 2^ADDR_W words of 32 bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
jdo  in  38  JTAG data from the debug slave; fields defined under Behaviour
take_action_ocimem_a  in  1  1-cycle strobe: address load / read command
take_action_ocimem_b  in  1  1-cycle strobe: JTAG write, data jdo[34:3]
take_no_action_ocimem_a  in  1  1-cycle strobe: read next word
address  in  ADDR_W  Avalon word address
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  32  Avalon write data
byteenable  in  4  Avalon byte enables
debugaccess  in  1  qualifies Avalon writes
readdata  out  32  Avalon read data
waitrequest  out  1  Avalon stall
MonDReg  out  32  monitor data register, to the debug slave
monitor_ready  out  1  high when no JTAG operation is pending or executing
monitor_error  out  1  sticky JTAG command-overflow flag

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - MonDReg=0, internal address register MonAReg=0, readdata=0.
  - waitrequest=1, monitor_ready=1, monitor_error=0.
  - Pending register cleared; FSM in IDLE.
  - RAM contents are not reset.
- jdo fields:
  - Address: jdo[26+:ADDR_W].
  - Read request: jdo[35] (used with ocimem_a).
  - Clear error: jdo[37] (used with ocimem_a).
  - Write data: jdo[34:3].
- JTAG capture, on any strobe cycle:
  - If exactly one strobe is asserted and the pending register is empty, capture opcode and data. Opcodes: ADDR (ocimem_a, jdo[35]=0), ADDRRD (ocimem_a, jdo[35]=1), WR (ocimem_b), RDNEXT (no_action_ocimem_a).
  - If the pending register is full, or more than one strobe is asserted in the same cycle: drop the command and set monitor_error=1.
  - monitor_error clears only when an ocimem_a command with jdo[37]=1 is captured. The clear wins over a same-cycle overflow set.
- monitor_ready is registered:
  - Low from the cycle after capture until the operation completes.
  - High again in the cycle after the JT_DONE state.
- FSM states: IDLE, JT_RD, JT_WR, JT_DONE, AV_RD, AV_WR, AV_DONE.
- IDLE priority: a pending JTAG op always wins over an Avalon request.
  - ADDR: MonAReg<=field; clear pending; stay IDLE (1 cycle).
  - ADDRRD: MonAReg<=field; go to JT_RD.
  - RDNEXT: go to JT_RD.
  - WR: go to JT_WR.
  - Avalon read: go to AV_RD.
  - Avalon write: go to AV_WR.
- JT_RD:
  - RAM read at MonAReg; go to JT_DONE.
  - In JT_DONE: MonDReg<=RAM q; MonAReg<=MonAReg+1; clear pending; go to IDLE.
- JT_WR:
  - RAM[MonAReg]<=data with all bytes written; MonDReg<=data; MonAReg<=MonAReg+1; go to JT_DONE.
  - JT_DONE then clears pending and goes to IDLE.
- MonAReg wraps modulo 2^ADDR_W; all-ones increments to 0.
- AV_RD:
  - RAM read at address; go to AV_DONE.
  - In AV_DONE: readdata<=RAM q; waitrequest=0 for exactly this cycle; go to IDLE.
- AV_WR:
  - If debugaccess=1: write the byte lanes enabled by byteenable.
  - If debugaccess=0: discard the write (no error).
  - Go to AV_DONE; waitrequest=0; go to IDLE.
- waitrequest is combinational: 0 only in AV_DONE, 1 otherwise, including idle with no request.
- An Avalon transfer therefore completes in 3 cycles at best. The master must hold its signals while waitrequest=1.
- A JTAG command arriving during an Avalon transfer is captured and executes after AV_DONE.
- Reset asserted mid-operation: everything returns to reset values immediately. An in-flight RAM write may or may not have landed.

Optional Feature:
OCIMEM_ROM_PROTECT_EN
- Defined: Avalon writes to the upper half of the address space (address MSB=1) are discarded even with debugaccess=1. They still complete with normal waitrequest timing. JTAG writes to that region are unaffected.
- Undefined: the whole RAM is Avalon-writable under debugaccess.

Test Plan:
- Reset, then idle: monitor_ready=1, monitor_error=0, waitrequest=1, MonDReg=0.
- JTAG load and write:
  - ocimem_a with address field 0x10 and jdo[35]=0, then ocimem_b with jdo[34:3]=0xDEADBEEF.
  - Then ocimem_a with address field 0x10 and jdo[35]=1 → MonDReg=0xDEADBEEF, MonAReg=0x11.
  - monitor_ready is low for 3 cycles per read/write.
- Wrap:
  - ADDR=0xFF, write 0x1, write 0x2 → RAM[0xFF]=1, RAM[0]=2.
  - ADDR 0xFF, ADDRRD, then RDNEXT → MonDReg reads 1, then 2.
- Avalon:
  - Write 0xA5A5A5A5 to address 3 with byteenable=0b0011 and debugaccess=1, over RAM 0 → Avalon read returns 0x0000A5A5.
  - waitrequest=0 only in the 3rd cycle.
  - Same write with debugaccess=0 → RAM unchanged.
- Contention:
  - Issue an Avalon read, then a JTAG WR one cycle later → the read finishes first, then the WR executes.
  - A second JTAG strobe while pending → monitor_error=1.
  - Later ocimem_a with jdo[37]=1 → monitor_error=0.
- Strobes ocimem_a and ocimem_b in the same cycle → monitor_error=1, no op executes.
  - With OCIMEM_ROM_PROTECT_EN: Avalon write to 0x80 with debugaccess=1 leaves the RAM unchanged.
